// File: rtl/mmio_timer_bank.sv
// Memory-mapped timer bank: 64-bit cycle counter with snapshot,
// auto-reload down-counter with irq, and byte-writable scratch.
// Ports: clk, rst (sync, high), ena, mem_* bus, hit, irq.
package pkg;
   typedef logic [1:0] mem_access_t;
   localparam mem_access_t MEM_ACCESS_BYTE = 2'd0;
   localparam mem_access_t MEM_ACCESS_HALF = 2'd1;
   localparam mem_access_t MEM_ACCESS_WORD = 2'd2;
   typedef struct packed {
      logic access_fault;
      logic misaligned;
   } mem_exception_mask_t;
   localparam logic [3:0] MMU_BANK_PERIPH = 4'h8;
endpackage

module mmio_timer_bank
   import pkg::*;
#(
   parameter logic [3:0]  BANK         = MMU_BANK_PERIPH,
   parameter logic [31:0] RESET_RELOAD = 32'd0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [31:0]         mem_addr,
   input  logic [31:0]         mem_wr_data,
   input  logic                mem_wr_ena,
   input  mem_access_t         mem_access,
   output logic [31:0]         mem_rd_data,
   output mem_exception_mask_t mem_exception,
   output logic                hit,
   output logic                irq
);

   localparam logic [2:0] R_SNAP_LO  = 3'd0;
   localparam logic [2:0] R_SNAP_HI  = 3'd1;
   localparam logic [2:0] R_CTRL     = 3'd2;
   localparam logic [2:0] R_RELOAD   = 3'd3;
   localparam logic [2:0] R_COUNT    = 3'd4;
   localparam logic [2:0] R_STATUS   = 3'd5;
   localparam logic [2:0] R_SCRATCH  = 3'd6;
   localparam logic [2:0] R_CYCLE_LO = 3'd7;

   logic [63:0] cycle;
   logic [63:0] snap;
   logic [2:0]  ctrl;
   logic [31:0] reload;
   logic [31:0] count;
   logic        expired;
   logic [31:0] scratch;

   logic [2:0] idx;
   logic       is_b, is_h, is_w;
   logic       mapped, ro, misal, fault, ok, wr;
   logic [3:0] be;
   logic [31:0] rdata;

   assign hit  = mem_addr[31:28] == BANK;
   assign idx  = mem_addr[4:2];
   assign is_b = mem_access == MEM_ACCESS_BYTE;
   assign is_h = mem_access == MEM_ACCESS_HALF;
   assign is_w = mem_access == MEM_ACCESS_WORD;

   assign mapped = mem_addr[27:5] == '0;
   assign ro = (idx == R_SNAP_LO) || (idx == R_SNAP_HI)
            || (idx == R_CYCLE_LO);

   assign misal = (is_w && mem_addr[1:0] != 2'b00)
               || (is_h && mem_addr[0]);

   // Only SCRATCH accepts sub-word accesses.
   assign fault = !(is_b || is_h || is_w)
               || !mapped
               || (!is_w && idx != R_SCRATCH)
               || (mem_wr_ena && ro);

   assign ok = hit && !misal && !fault;
   assign wr = ok && mem_wr_ena && ena;

   assign mem_exception.misaligned   = hit && misal;
   assign mem_exception.access_fault = hit && !misal && fault;

   always_comb begin
      be = 4'b0000;
      if (is_w)      be = 4'b1111;
      else if (is_h) be = mem_addr[1] ? 4'b1100 : 4'b0011;
      else if (is_b) be = 4'b0001 << mem_addr[1:0];
   end

   always_comb begin
      rdata = '0;
      case (idx)
         R_SNAP_LO:  rdata = snap[31:0];
         R_SNAP_HI:  rdata = snap[63:32];
         R_CTRL:     rdata = {29'd0, ctrl};
         R_RELOAD:   rdata = reload;
         R_COUNT:    rdata = count;
         R_STATUS:   rdata = {31'd0, expired};
         R_SCRATCH:  rdata = scratch;
         R_CYCLE_LO: rdata = cycle[31:0];
         default:    rdata = '0;
      endcase
   end

   assign mem_rd_data = ok ? rdata : '0;
   assign irq = expired & ctrl[2];

   // Later assignments win: W1C clear < timer < CPU COUNT/CTRL.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle   <= '0;
         snap    <= '0;
         ctrl    <= '0;
         reload  <= RESET_RELOAD;
         count   <= '0;
         expired <= 1'b0;
         scratch <= '0;
      end else if (ena) begin
         cycle <= cycle + 64'd1;

         if (wr && idx == R_STATUS && mem_wr_data[0])
            expired <= 1'b0;

         if (ctrl[0]) begin
            if (count != '0) begin
               count <= count - 32'd1;
            end else begin
               expired <= 1'b1;
               if (ctrl[1]) count   <= reload;
               else         ctrl[0] <= 1'b0;
            end
         end

         if (wr && idx == R_CTRL) begin
            ctrl <= mem_wr_data[2:0];
            if (mem_wr_data[3]) snap <= cycle;
         end
         if (wr && idx == R_RELOAD) reload <= mem_wr_data;
         if (wr && idx == R_COUNT)  count  <= mem_wr_data;
         if (wr && idx == R_SCRATCH) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) scratch[8*i +: 8] <= mem_wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed self-checking bench for mmio_timer_bank.
// Drives the bus from one initial block and checks with assertions.
module tb_mmio_timer_bank;
   import pkg::*;

   localparam logic [31:0] RR = 32'h0000_0005;

   logic                clk;
   logic                rst;
   logic                ena;
   logic [31:0]         mem_addr;
   logic [31:0]         mem_wr_data;
   logic                mem_wr_ena;
   mem_access_t         mem_access;
   logic [31:0]         mem_rd_data;
   mem_exception_mask_t mem_exception;
   logic                hit;
   logic                irq;

   int checks = 0;
   int failures = 0;

   logic [31:0] rd_val;
   logic [1:0]  exc_val;
   logic        hit_val;
   logic [63:0] mc;
   logic [63:0] cb;

   mmio_timer_bank #(
      .BANK(MMU_BANK_PERIPH),
      .RESET_RELOAD(RR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data),
      .mem_wr_ena(mem_wr_ena),
      .mem_access(mem_access),
      .mem_rd_data(mem_rd_data),
      .mem_exception(mem_exception),
      .hit(hit),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference cycle counter.
   always @(posedge clk) begin
      if (rst)      mc <= '0;
      else if (ena) mc <= mc + 64'd1;
   end

   function automatic logic [31:0] a(input logic [27:0] off);
      return {MMU_BANK_PERIPH, off};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] ad, input mem_access_t ac);
      mem_addr    = ad;
      mem_access  = ac;
      mem_wr_ena  = 1'b0;
      mem_wr_data = '0;
      #1;
      rd_val  = mem_rd_data;
      exc_val = mem_exception;
      hit_val = hit;
   endtask

   task automatic wr(input logic [31:0] ad, input logic [31:0] d,
                     input mem_access_t ac);
      mem_addr    = ad;
      mem_access  = ac;
      mem_wr_data = d;
      mem_wr_ena  = 1'b1;
      #1;
      exc_val = mem_exception;
      @(posedge clk);
      #1;
      mem_wr_ena = 1'b0;
   endtask

   task automatic rw(input logic [27:0] off, input logic [63:0] exp,
                     input string tag);
      rd(a(off), MEM_ACCESS_WORD);
      chk(tag, rd_val, exp);
   endtask

   initial begin
      rst         = 1'b1;
      ena         = 1'b1;
      mem_addr    = '0;
      mem_wr_data = '0;
      mem_wr_ena  = 1'b0;
      mem_access  = MEM_ACCESS_WORD;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      rw(28'h08, 0, "rst_ctrl");
      rw(28'h10, 0, "rst_count");
      rw(28'h14, 0, "rst_status");
      rw(28'h0C, RR, "rst_reload");
      chk("rst_irq", irq, 0);
      chk("rst_exc", exc_val, 0);

      // Auto-reload timer, period RELOAD+1
      wr(a(28'h0C), 3, MEM_ACCESS_WORD);
      wr(a(28'h10), 3, MEM_ACCESS_WORD);
      wr(a(28'h08), 7, MEM_ACCESS_WORD);
      tick(3);
      rw(28'h10, 0, "ar_count0");
      chk("ar_irq_pre", irq, 0);
      tick(1);
      chk("ar_irq", irq, 1);
      rw(28'h14, 1, "ar_status");
      rw(28'h10, 3, "ar_reload");
      tick(4);
      rw(28'h10, 3, "ar_reload2");
      wr(a(28'h14), 1, MEM_ACCESS_WORD);
      chk("w1c_irq", irq, 0);
      rw(28'h14, 0, "w1c_status");
      tick(2);
      rw(28'h14, 0, "ar_pre_exp");
      tick(1);
      rw(28'h14, 1, "ar_exp2");
      tick(3);
      wr(a(28'h14), 1, MEM_ACCESS_WORD);
      rw(28'h14, 1, "w1c_vs_exp");
      chk("w1c_vs_exp_irq", irq, 1);
      wr(a(28'h08), 0, MEM_ACCESS_WORD);
      wr(a(28'h14), 1, MEM_ACCESS_WORD);
      rw(28'h14, 0, "clr_status");

      // One-shot
      wr(a(28'h10), 2, MEM_ACCESS_WORD);
      wr(a(28'h08), 1, MEM_ACCESS_WORD);
      tick(2);
      rw(28'h14, 0, "os_pre");
      tick(1);
      rw(28'h14, 1, "os_exp");
      rw(28'h08, 0, "os_ctrl");
      rw(28'h10, 0, "os_count");
      chk("os_irq", irq, 0);
      tick(2);
      rw(28'h10, 0, "os_count_hold");
      wr(a(28'h14), 1, MEM_ACCESS_WORD);

      // CPU COUNT write beats decrement
      wr(a(28'h10), 9, MEM_ACCESS_WORD);
      wr(a(28'h08), 1, MEM_ACCESS_WORD);
      tick(1);
      rw(28'h10, 8, "dec");
      wr(a(28'h10), 20, MEM_ACCESS_WORD);
      rw(28'h10, 20, "cnt_wr_wins");
      tick(1);
      rw(28'h10, 19, "cnt_after");
      wr(a(28'h08), 0, MEM_ACCESS_WORD);

      // CPU CTRL write beats hardware enable clear
      wr(a(28'h10), 0, MEM_ACCESS_WORD);
      wr(a(28'h08), 1, MEM_ACCESS_WORD);
      wr(a(28'h08), 5, MEM_ACCESS_WORD);
      rw(28'h08, 5, "ctrl_wr_wins");
      rw(28'h14, 1, "ctrl_wr_exp");
      chk("ctrl_wr_irq", irq, 1);
      wr(a(28'h08), 0, MEM_ACCESS_WORD);
      wr(a(28'h14), 1, MEM_ACCESS_WORD);

      // SCRATCH sub-word writes
      wr(a(28'h18), 32'h1122_3344, MEM_ACCESS_WORD);
      wr(a(28'h1A), 32'h00AA_0000, MEM_ACCESS_BYTE);
      chk("byte_exc", exc_val, 0);
      wr(a(28'h18), 32'h0000_BEEF, MEM_ACCESS_HALF);
      rw(28'h18, 32'h11AA_BEEF, "scratch_mix");
      wr(a(28'h1A), 32'h1234_0000, MEM_ACCESS_HALF);
      rw(28'h18, 32'h1234_BEEF, "scratch_hi");

      // Faults
      rd(a(28'h0E), MEM_ACCESS_WORD);
      chk("mis_exc", exc_val, 2'b01);
      chk("mis_rd", rd_val, 0);
      rd(a(28'h19), MEM_ACCESS_HALF);
      chk("mis_half", exc_val, 2'b01);
      wr(a(28'h08), 4, MEM_ACCESS_WORD);
      wr(a(28'h08), 7, MEM_ACCESS_HALF);
      chk("half_ctrl_exc", exc_val, 2'b10);
      rw(28'h08, 4, "half_ctrl_keep");
      wr(a(28'h08), 0, MEM_ACCESS_WORD);
      wr(a(28'h1C), 1, MEM_ACCESS_WORD);
      chk("ro_wr_exc", exc_val, 2'b10);
      rd(a(28'h40), MEM_ACCESS_WORD);
      chk("unmap_exc", exc_val, 2'b10);
      chk("unmap_rd", rd_val, 0);
      rd(a(28'h18), 2'd3);
      chk("badacc_exc", exc_val, 2'b10);
      rd({4'h1, 28'h08}, MEM_ACCESS_WORD);
      chk("nohit_hit", hit_val, 0);
      chk("nohit_exc", exc_val, 0);
      chk("nohit_rd", rd_val, 0);
      wr({4'h1, 28'h08}, 7, MEM_ACCESS_WORD);
      rw(28'h08, 0, "nohit_nowr");
      rd(a(28'h08), MEM_ACCESS_WORD);
      chk("hit", hit_val, 1);

      // Snapshot
      tick(100);
      rw(28'h1C, {32'd0, mc[31:0]}, "cycle_lo");
      cb = mc;
      wr(a(28'h08), 8, MEM_ACCESS_WORD);
      rw(28'h00, {32'd0, cb[31:0]}, "snap_lo");
      rw(28'h04, {32'd0, cb[63:32]}, "snap_hi");
      rw(28'h08, 0, "snap_ctrl");

      // ena=0 freeze
      wr(a(28'h10), 50, MEM_ACCESS_WORD);
      wr(a(28'h08), 1, MEM_ACCESS_WORD);
      rw(28'h10, 50, "frz_pre");
      ena = 1'b0;
      cb = mc;
      wr(a(28'h10), 7, MEM_ACCESS_WORD);
      tick(4);
      rw(28'h10, 50, "frz_count");
      rw(28'h1C, {32'd0, cb[31:0]}, "frz_cycle");
      ena = 1'b1;
      tick(1);
      rw(28'h10, 49, "unfrz_count");

      // Reset mid-countdown
      rst = 1'b1;
      tick(1);
      rw(28'h10, 0, "mrst_count");
      rw(28'h08, 0, "mrst_ctrl");
      rw(28'h0C, RR, "mrst_reload");
      rw(28'h18, 0, "mrst_scratch");
      rw(28'h1C, 0, "mrst_cycle");
      rw(28'h00, 0, "mrst_snap");
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
